// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA decryption datapath: operand width and the
// modular-multiplier controller state encoding.
package rsa_pkg;

  localparam int RSA_WIDTH = 512;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV_REQ,
    DIV_WAIT,
    DONE
  } mm_state_t;

endpackage

// File: rtl/mod_mult_ctrl_if.sv
// Link between the modular-multiplier controller (master) and the
// non-restoring divider (slave): dividend halves, modulus, remainder, handshake.
interface mod_mult_ctrl_if
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
);

  logic             div_start;
  logic [WIDTH-1:0] div_a;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_m;
  logic [WIDTH-1:0] div_r;
  logic             div_done;

  modport master (
    output div_start, div_a, div_q, div_m,
    input  div_r, div_done
  );

  modport slave (
    input  div_start, div_a, div_q, div_m,
    output div_r, div_done
  );

endinterface

// File: rtl/shift_add_mul.sv
// Sequential shift-add multiplier: one partial product per step, full
// 2*WIDTH-bit product left in {hi, lo} after WIDTH steps.
module shift_add_mul
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             last
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] mplr;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   sum;

  // Carry of the add lands in sum[WIDTH] so the right shift keeps it.
  always_comb begin
    sum = {1'b0, hi};
    if (mplr[0]) begin
      sum = {1'b0, hi} + {1'b0, a_reg};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      mplr  <= '0;
      hi    <= '0;
      lo    <= '0;
      count <= '0;
    end else if (load) begin
      a_reg <= a;
      mplr  <= b;
      hi    <= '0;
      lo    <= '0;
      count <= CW'(WIDTH);
    end else if (step) begin
      hi    <= sum[WIDTH:1];
      lo    <= {sum[0], lo[WIDTH-1:1]};
      mplr  <= mplr >> 1;
      count <= count - CW'(1);
    end
  end

  assign last = (count == CW'(1));

endmodule

// File: rtl/mod_mult_ctrl.sv
// Modular multiplier front end: result = (a*b) mod n via shift-add multiply
// followed by the external divider. Optional operand check: MODMUL_RANGE_CHECK_EN.
module mod_mult_ctrl
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   n,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               err,
  mod_mult_ctrl_if.master    div
);

  mm_state_t        state;
  logic [WIDTH-1:0] n_reg;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             mul_load;
  logic             mul_step;
  logic             mul_last;
  logic             range_bad;

`ifdef MODMUL_RANGE_CHECK_EN
  assign range_bad = (a >= n) || (b >= n) || (n == '0) || n[WIDTH-1];
`else
  assign range_bad = 1'b0;
`endif

  assign mul_load = (state == IDLE) && start;
  assign mul_step = (state == MUL);

  shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk  (clk),
    .rst  (rst),
    .load (mul_load),
    .step (mul_step),
    .a    (a),
    .b    (b),
    .hi   (hi),
    .lo   (lo),
    .last (mul_last)
  );

  // The product registers stop changing after the last step, so they drive
  // the divider directly and stay stable until the next accepted start.
  assign div.div_a = hi;
  assign div.div_q = lo;
  assign div.div_m = n_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      result        <= '0;
      n_reg         <= '0;
      div.div_start <= 1'b0;
    end else begin
      done          <= 1'b0;
      div.div_start <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            n_reg <= n;
            busy  <= 1'b1;
            err   <= range_bad;
            if (range_bad) begin
              result <= '0;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              state <= MUL;
            end
          end
        end
        MUL: begin
          if (mul_last) begin
            div.div_start <= 1'b1;
            state         <= DIV_REQ;
          end
        end
        DIV_REQ: state <= DIV_WAIT;
        DIV_WAIT: begin
          if (div.div_done) begin
            result <= div.div_r;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_mult_ctrl.sv
// Directed bench for mod_mult_ctrl with a behavioural divider responding
// W+2 cycles after div_start; build with MODMUL_RANGE_CHECK_EN to test the check.
module tb_mod_mult_ctrl;
  import rsa_pkg::*;

  localparam int W = RSA_WIDTH;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] n;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         err;

  logic         modelDone;
  logic         injDone;
  logic [W-1:0] modelR;

  int assertCount = 0;
  int failCount   = 0;

  int           doneCyc;
  int           divStartCyc;
  int           divStartCount;
  logic         busyT1;
  logic         errAtDone;
  logic [W-1:0] resAtDone;
  logic [W-1:0] capA;
  logic [W-1:0] capQ;
  logic [W-1:0] capM;

  logic [W-1:0] bigN;
  logic [W-1:0] bigOp;
  logic [W-1:0] expHi;
  int           staleStarts;
  int           staleDones;

  mod_mult_ctrl_if #(.WIDTH(W)) divBus ();

  assign divBus.div_done = modelDone | injDone;
  assign divBus.div_r    = modelR;

  mod_mult_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .n      (n),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err),
    .div    (divBus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural divider: div_done lands W+2 cycles after the div_start cycle.
  initial begin
    logic [2*W-1:0] dividend;
    logic [2*W-1:0] rem;
    logic [W-1:0]   divisor;
    modelDone = 1'b0;
    modelR    = '0;
    forever begin
      @(negedge clk);
      if (divBus.div_start === 1'b1) begin
        dividend = {divBus.div_a, divBus.div_q};
        divisor  = divBus.div_m;
        repeat (W + 2) @(posedge clk);
        #1;
        rem       = dividend % {{W{1'b0}}, divisor};
        modelR    = rem[W-1:0];
        modelDone = 1'b1;
        @(posedge clk);
        #1 modelDone = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [1023:0] observed,
                             input logic [1023:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Call at #1 after a rising edge; that cycle is T0. Start is re-pulsed in
  // cycles s1 and s2. Returns at #1 into the cycle after done.
  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb,
                               input logic [W-1:0] tn, input int s1, input int s2);
    int cyc;
    a = ta;
    b = tb;
    n = tn;
    start = 1'b1;
    doneCyc = -1;
    divStartCyc = -1;
    divStartCount = 0;
    busyT1 = 1'b0;
    errAtDone = 1'bx;
    resAtDone = 'x;
    capA = 'x;
    capQ = 'x;
    capM = 'x;
    @(posedge clk);
    #1;
    cyc = 1;
    while (doneCyc < 0 && cyc <= 2 * W + 20) begin
      start = (cyc == s1) || (cyc == s2);
      @(negedge clk);
      if (cyc == 1) busyT1 = busy;
      if (divBus.div_start === 1'b1) begin
        divStartCount++;
        divStartCyc = cyc;
        capA = divBus.div_a;
        capQ = divBus.div_q;
        capM = divBus.div_m;
      end
      if (done === 1'b1) begin
        doneCyc   = cyc;
        resAtDone = result;
        errAtDone = err;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    n = '0;
    injDone = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_div_start", divBus.div_start, 0);
    checkOutput("rst_div_m", divBus.div_m, 0);
    @(posedge clk);
    #1;

    // 1: 3*5 mod 7 = 1
    applyStimulus(3, 5, 7, -1, -1);
    checkOutput("t1_result", resAtDone, 1);
    checkOutput("t1_err", errAtDone, 0);
    checkOutput("t1_done_cycle", doneCyc, 1028);
    checkOutput("t1_div_start_cycle", divStartCyc, 513);
    checkOutput("t1_div_start_count", divStartCount, 1);
    checkOutput("t1_div_a", capA, 0);
    checkOutput("t1_div_q", capQ, 15);
    checkOutput("t1_div_m", capM, 7);
    checkOutput("t1_busy_T1", busyT1, 1);
    @(negedge clk);
    checkOutput("t1_busy_after", busy, 0);
    checkOutput("t1_result_hold", result, 1);
    @(posedge clk);
    #1;

    // 3: zero operand still runs the whole sequence
    applyStimulus(0, 12345, 99991, -1, -1);
    checkOutput("t3_result", resAtDone, 0);
    checkOutput("t3_done_cycle", doneCyc, 1028);
    checkOutput("t3_div_start_count", divStartCount, 1);
    @(posedge clk);
    #1;

    // 2: n = 2^511-1, a = b = n-1; product = 2^1022 - 2^513 + 4
    bigN  = {1'b0, {(W-1){1'b1}}};
    bigOp = bigN - W'(1);
    expHi = (W'(1) << 510) - W'(2);
    applyStimulus(bigOp, bigOp, bigN, -1, -1);
    checkOutput("t2_result", resAtDone, 1);
    checkOutput("t2_div_a", capA, expHi);
    checkOutput("t2_div_q", capQ, 4);
    checkOutput("t2_done_cycle", doneCyc, 1028);
    @(posedge clk);
    #1;

    // 5: reset in T200 of an operation, then a stale div_done in IDLE
    a = 12345;
    b = 6789;
    n = 99991;
    start = 1'b1;
    staleStarts = 0;
    staleDones = 0;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c < 200; c++) begin
      @(negedge clk);
      if (divBus.div_start === 1'b1) staleStarts++;
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_done", done, 0);
    checkOutput("t5_err", err, 0);
    checkOutput("t5_result", result, 0);
    checkOutput("t5_div_start", divBus.div_start, 0);
    checkOutput("t5_div_a", divBus.div_a, 0);
    checkOutput("t5_div_q", divBus.div_q, 0);
    checkOutput("t5_div_m", divBus.div_m, 0);
    @(posedge clk);
    #1 injDone = 1'b1;
    @(posedge clk);
    #1 injDone = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (divBus.div_start === 1'b1) staleStarts++;
      if (done === 1'b1 || busy === 1'b1) staleDones++;
      @(posedge clk);
      #1;
    end
    checkOutput("t5_no_div_start", staleStarts, 0);
    checkOutput("t5_idle_after_stale", staleDones, 0);
    checkOutput("t5_result_after_stale", result, 0);

    // 4: starts at T10 and at the done cycle ignored; back-to-back at T1029
    applyStimulus(10, 20, 23, 10, 1028);
    checkOutput("t4a_result", resAtDone, 16);
    checkOutput("t4a_done_cycle", doneCyc, 1028);
    checkOutput("t4a_div_start_count", divStartCount, 1);
    applyStimulus(5, 6, 11, -1, -1);
    checkOutput("t4b_result", resAtDone, 8);
    checkOutput("t4b_done_cycle", doneCyc, 1028);
    @(posedge clk);
    #1;

    // 6: a == n
    applyStimulus(7, 2, 7, -1, -1);
`ifdef MODMUL_RANGE_CHECK_EN
    checkOutput("t6_done_cycle", doneCyc, 1);
    checkOutput("t6_err", errAtDone, 1);
    checkOutput("t6_result", resAtDone, 0);
    checkOutput("t6_div_start_count", divStartCount, 0);
    checkOutput("t6_busy_T1", busyT1, 1);
`else
    checkOutput("t6_done_cycle", doneCyc, 1028);
    checkOutput("t6_err", errAtDone, 0);
    checkOutput("t6_result", resAtDone, 0);
    checkOutput("t6_div_start_count", divStartCount, 1);
`endif
    @(negedge clk);
    checkOutput("t6_busy_after", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mod_mult_ctrl.md
# mod_mult_ctrl

Sequential modular multiplier front end for the RSA decryption datapath. It computes the full 2·WIDTH-bit product of `a` and `b` with a shift-add multiplier and hands the product to `nonrestoringdiv`: high half on `A`, low half on `Q`, modulus on `M`. It then captures the divider's remainder as `result = (a·b) mod n`. It is the stage directly upstream of the divider and the only consumer of the divider's remainder.

## Interface
Parameters:
- `WIDTH`, 512, operand and modulus width; must match the divider width.

Ports:
- `clk`  in  1  — single clock; all logic on rising edge.
- `rst`  in  1  — reset, synchronous, active-high.
- `start`  in  1  — request; sampled only in IDLE.
- `a`, `b`  in  WIDTH  — multiplicands; must satisfy `a < n` and `b < n`.
- `n`  in  WIDTH  — modulus; must be nonzero with `n[WIDTH-1] == 0`.
- `busy`  out  1  — high in every state except IDLE.
- `done`  out  1  — one-cycle pulse when `result` becomes valid.
- `result`  out  WIDTH  — modular product; holds until the next accepted start.
- `err`  out  1  — range-check failure flag, valid with `done`; see Configuration.
- `div_start`  out  1  — to divider `start`.
- `div_a`, `div_q`, `div_m`  out  WIDTH  — to divider `A`, `Q`, `M`.
- `div_r`  in  WIDTH  — from divider `R`.
- `div_done`  in  1  — from divider `done`.

## Operation
States and transitions:
- **IDLE**
  - On `start`: latch `a`, `b`, `n`; clear `{carry, hi, lo}`; load a WIDTH-cycle counter; go to MUL.
- **MUL**, one iteration per cycle:
  - If the multiplier LSB is 1, `{carry, hi} = hi + a_reg`, computed at WIDTH+1 bits.
  - Then shift `{carry, hi, lo}` right by 1, feeding the multiplier LSB into `lo[WIDTH-1]`.
  - Shift the multiplier register right by 1 and decrement the counter.
  - After WIDTH iterations, `{hi, lo} = a·b`; go to DIV_REQ.
- **DIV_REQ**: drive `div_a = hi`, `div_q = lo`, `div_m = n_reg`; assert `div_start` for exactly this cycle; go to DIV_WAIT.
- **DIV_WAIT**: on `div_done`, latch `result <= div_r`; go to DONE.
- **DONE**: `done = 1` for one cycle; go to IDLE.

Data and range rules:
- `div_a`, `div_q`, `div_m` are registered and held stable from DIV_REQ until the next accepted start.
- Given `a, b < n < 2^(WIDTH-1)`, `hi < n`. This satisfies the divider's range requirement.
- Behaviour for out-of-range operands is undefined unless the range check is compiled in.

Reset values:
- `busy`, `done`, `err`, `div_start` = 0.
- `result`, `div_a`, `div_q`, `div_m` = 0.
- State = IDLE.

Boundary conditions:
- `start` while busy: ignored, with no effect on state or outputs.
- `start` in the same cycle as `done`: ignored, because the FSM is in DONE, not IDLE.
- `div_done` outside DIV_WAIT: ignored.
- `rst` mid-operation:
  - Returns the block to IDLE with reset values on the next edge.
  - The divider has no reset. The system must assert `rst` to both blocks together, or hold `start` low for WIDTH+3 cycles after reset.
- `a == 0` or `b == 0`: full sequence still runs; `result = 0`.

## Timing
All counts are relative to cycle T0, in which `start` is high in IDLE.

| Cycle | Event |
|---|---|
| T1 … TWIDTH | MUL |
| TWIDTH+1 | DIV_REQ (`div_start` high) |
| T2·WIDTH+3 | `div_done` high |
| T2·WIDTH+4 | `done` high |

- End-to-end latency is 2·WIDTH+4 cycles; for WIDTH = 512, `done` rises at T1028.
- DIV_WAIT has no timeout. Latency scales with the divider's actual response.
- Throughput is one operation per 2·WIDTH+5 cycles, since the next start is accepted at T2·WIDTH+5.

## Configuration
Macro: `MODMUL_RANGE_CHECK_EN`.

- **Defined:**
  - In IDLE, on `start`, check the operands in the same cycle.
  - If `a >= n`, or `b >= n`, or `n == 0`, or `n[WIDTH-1] == 1`: go directly to DONE.
  - In that case `err = 1` and `result = 0` with the `done` pulse at T1, and `div_start` is never asserted.
  - Otherwise `err = 0` and the normal sequence runs.
- **Undefined:** no comparators; `err` is tied to 0; every start runs the full sequence.

## Structure
- Shared package `rsa_pkg` holds:
  - the `RSA_WIDTH = 512` constant, used as the default for `WIDTH`;
  - the FSM state enum `mm_state_t` (IDLE, MUL, DIV_REQ, DIV_WAIT, DONE).
- One natural sub-module, `shift_add_mul`:
  - contains the multiplier and counter datapath;
  - interface: `load`, `step`, operands in, `{hi, lo}` out, `last` flag.
- `mod_mult_ctrl` keeps the FSM, the divider handshake and the range check.

## Test plan
Each scenario uses `mod_mult_ctrl` connected to a real `nonrestoringdiv`, WIDTH = 512, with result checked against a reference model.

1. `a=3`, `b=5`, `n=7` → `result=1`, `err=0`. `done` high exactly at T1028; `div_start` high only at T513, with `div_a=0`, `div_q=15`.
2. `n = 2^511-1`, `a = b = n-1` → `result=1`. Check `div_a`/`div_q` against the exact 1024-bit product.
3. `a=0`, `b=12345`, `n=99991` → `result=0`, `done` at T1028.
4. Second `start` pulses at T10 and at the `done` cycle → both ignored. A `start` at T1029 is accepted, and its `done` comes 1028 cycles later.
5. `rst` at T200 → next cycle all outputs 0, `busy=0`. `div_start` is never pulsed; a stale `div_done` injected in IDLE is ignored.
6. Range check with `a=7`, `n=7`:
   - With `MODMUL_RANGE_CHECK_EN`: `done` and `err=1` at T1, `result=0`, no `div_start`.
   - Without it: the full sequence runs and `err` stays 0.
